// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder front end: IEEE-754 single
// field positions, datapath widths and the alignment sequencer state set.
package fp_pkg;

    localparam int MANT_W   = 24;
    localparam int EXP_W    = 8;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_LOAD,
        ST_ARM,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single word into sign, raw/effective exponent and the
// 24-bit mantissa with its hidden bit restored.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       i_word,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp_raw,
    output logic [EXP_W-1:0]  o_exp_eff,
    output logic [MANT_W-1:0] o_mant
);

    logic w_normal;

    assign o_sign    = i_word[SIGN_BIT];
    assign o_exp_raw = i_word[EXP_MSB:EXP_LSB];
    assign w_normal  = |o_exp_raw;

    // Denormals share the scale of exponent 1, so they align as if exp were 1.
    assign o_exp_eff = w_normal ? o_exp_raw : EXP_W'(1);
    assign o_mant    = {w_normal, i_word[MANT_MSB:0]};

endmodule

// File: rtl/fp_align_sequencer.sv
// Exponent alignment controller: picks the larger-exponent operand, drives the
// external count shifter to align the smaller mantissa, and hands the pair on.
module fp_align_sequencer #(
    parameter int MANT_W   = fp_pkg::MANT_W,
    parameter int EXP_W    = fp_pkg::EXP_W,
    parameter int MAX_WAIT = 40
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_op_a,
    input  logic [31:0]       i_op_b,
    output logic              o_sh_load,
    output logic [MANT_W-1:0] o_sh_data,
    output logic [EXP_W-1:0]  o_sh_count,
    output logic              o_sh_direction,
    output logic              o_sh_clear,
    input  logic [MANT_W-1:0] i_sh_result,
    input  logic              i_sh_done,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [MANT_W-1:0] o_big_mant,
    output logic [MANT_W-1:0] o_small_mant,
    output logic [EXP_W-1:0]  o_common_exp,
    output logic              o_big_sign,
    output logic              o_small_sign,
    output logic              o_swapped,
    output logic              o_err_timeout,
    output logic              o_busy
);

    import fp_pkg::*;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t              r_state;
    state_t              w_next;

    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic [MANT_W-1:0]   r_big_mant;
    logic [MANT_W-1:0]   r_small_mant;
    logic [EXP_W-1:0]    r_common_exp;
    logic                r_big_sign;
    logic                r_small_sign;
    logic                r_swapped;
    logic                r_err_timeout;
    logic [MANT_W-1:0]   r_sh_data;
    logic [EXP_W-1:0]    r_sh_count;
    logic [WAIT_W-1:0]   r_wait;

    logic                w_sign_a;
    logic                w_sign_b;
    logic [EXP_W-1:0]    w_exp_raw_a;
    logic [EXP_W-1:0]    w_exp_raw_b;
    logic [EXP_W-1:0]    w_exp_eff_a;
    logic [EXP_W-1:0]    w_exp_eff_b;
    logic [MANT_W-1:0]   w_mant_a;
    logic [MANT_W-1:0]   w_mant_b;

    logic                w_b_big;
    logic [EXP_W-1:0]    w_big_eff;
    logic [EXP_W-1:0]    w_small_eff;
    logic [EXP_W-1:0]    w_diff;
    logic [MANT_W-1:0]   w_small_raw;
    logic                w_diff_zero;
    logic                w_diff_over;
    logic                w_timeout;

    fp_unpack u_unpack_a (
        .i_word    (r_op_a),
        .o_sign    (w_sign_a),
        .o_exp_raw (w_exp_raw_a),
        .o_exp_eff (w_exp_eff_a),
        .o_mant    (w_mant_a)
    );

    fp_unpack u_unpack_b (
        .i_word    (r_op_b),
        .o_sign    (w_sign_b),
        .o_exp_raw (w_exp_raw_b),
        .o_exp_eff (w_exp_eff_b),
        .o_mant    (w_mant_b)
    );

    // Ties keep A as the big operand so equal exponents never report a swap.
    assign w_b_big     = w_exp_eff_b > w_exp_eff_a;
    assign w_big_eff   = w_b_big ? w_exp_eff_b : w_exp_eff_a;
    assign w_small_eff = w_b_big ? w_exp_eff_a : w_exp_eff_b;
    assign w_diff      = w_big_eff - w_small_eff;
    assign w_small_raw = w_b_big ? w_mant_a : w_mant_b;
    assign w_diff_zero = (w_diff == '0);
    assign w_diff_over = (w_diff > EXP_W'(MANT_W));
    assign w_timeout   = (r_wait == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b1;
        o_out_valid = 1'b0;
        o_sh_load   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
                if (i_in_valid) begin
                    w_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_diff_zero || w_diff_over) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_sh_load = 1'b1;
                w_next    = ST_ARM;
            end
            // The shifter is still taking the new count here, so its done flag is stale.
            ST_ARM: begin
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (i_sh_done || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_big_mant    <= '0;
            r_small_mant  <= '0;
            r_common_exp  <= '0;
            r_big_sign    <= 1'b0;
            r_small_sign  <= 1'b0;
            r_swapped     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_sh_data     <= '0;
            r_sh_count    <= '0;
            r_wait        <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_op_a <= i_op_a;
                        r_op_b <= i_op_b;
                    end
                end
                ST_COMPARE: begin
                    r_big_mant    <= w_b_big ? w_mant_b : w_mant_a;
                    r_common_exp  <= w_b_big ? w_exp_raw_b : w_exp_raw_a;
                    r_big_sign    <= w_b_big ? w_sign_b : w_sign_a;
                    r_small_sign  <= w_b_big ? w_sign_a : w_sign_b;
                    r_swapped     <= w_b_big;
                    r_err_timeout <= 1'b0;
                    r_wait        <= '0;
                    r_small_mant  <= w_diff_zero ? w_small_raw : '0;
                    // Shift amounts past the mantissa width flush to zero without the shifter.
                    if (!w_diff_zero && !w_diff_over) begin
                        r_sh_data  <= w_small_raw;
                        r_sh_count <= w_diff;
                    end
                end
                ST_SHIFT: begin
                    if (i_sh_done) begin
                        r_small_mant <= i_sh_result;
                    end else if (w_timeout) begin
                        r_small_mant  <= '0;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_err_timeout <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sh_data      = r_sh_data;
    assign o_sh_count     = r_sh_count;
    assign o_sh_direction = 1'b0;
    assign o_sh_clear     = i_clear;
    assign o_big_mant     = r_big_mant;
    assign o_small_mant   = r_small_mant;
    assign o_common_exp   = r_common_exp;
    assign o_big_sign     = r_big_sign;
    assign o_small_sign   = r_small_sign;
    assign o_swapped      = r_swapped;
    assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Self-checking bench for fp_align_sequencer: a count-shifter model, an
// arithmetic reference of the alignment result, and directed operand pairs.
module tb_fp_align_sequencer;

    localparam int MAX_WAIT = 40;

    logic        clk = 1'b0;
    logic        clear;
    logic        inValid;
    logic        outReady;
    logic [31:0] opA;
    logic [31:0] opB;

    logic        inReady;
    logic        shLoad;
    logic [23:0] shData;
    logic [7:0]  shCount;
    logic        shDirection;
    logic        shClear;
    logic [23:0] shResult;
    logic        shDone;
    logic        outValid;
    logic [23:0] bigMant;
    logic [23:0] smallMant;
    logic [7:0]  commonExp;
    logic        bigSign;
    logic        smallSign;
    logic        swapped;
    logic        errTimeout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;
    bit stuck;

    typedef struct packed {
        logic [23:0] bigMant;
        logic [23:0] smallMant;
        logic [23:0] smallRaw;
        logic [7:0]  cexp;
        logic [7:0]  diff;
        bit          bs;
        bit          ss;
        bit          sw;
        bit          err;
        bit          shift;
        int          lat;
    } model_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        bit          stk;
        logic [23:0] bigMant;
        logic [23:0] smallMant;
        logic [7:0]  cexp;
        bit          sw;
        bit          bs;
        bit          err;
        int          lat;
    } row_t;

    row_t   rows [11];
    model_t mExp;
    bit     mBusy;
    int     mCount;

    fp_align_sequencer #(.MANT_W(24), .EXP_W(8), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk          (clk),
        .i_clear        (clear),
        .i_in_valid     (inValid),
        .o_in_ready     (inReady),
        .i_op_a         (opA),
        .i_op_b         (opB),
        .o_sh_load      (shLoad),
        .o_sh_data      (shData),
        .o_sh_count     (shCount),
        .o_sh_direction (shDirection),
        .o_sh_clear     (shClear),
        .i_sh_result    (shResult),
        .i_sh_done      (shDone),
        .o_out_valid    (outValid),
        .i_out_ready    (outReady),
        .o_big_mant     (bigMant),
        .o_small_mant   (smallMant),
        .o_common_exp   (commonExp),
        .o_big_sign     (bigSign),
        .o_small_sign   (smallSign),
        .o_swapped      (swapped),
        .o_err_timeout  (errTimeout),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // External count shifter: loads data/count, then shifts right once per cycle until the count runs out.
    logic [23:0] shReg;
    logic [7:0]  shCnt;

    always @(posedge clk) begin
        if (shClear) begin
            shReg <= '0;
            shCnt <= '0;
        end else if (shLoad) begin
            shReg <= shData;
            shCnt <= shCount;
        end else if (shCnt != 0) begin
            shReg <= shReg >> 1;
            shCnt <= shCnt - 8'd1;
        end
    end

    assign shResult = shReg;
    assign shDone   = (shCnt == 0) && !stuck;

    // Reference result computed straight from the IEEE field arithmetic.
    function automatic model_t modelOf(input logic [31:0] a, input logic [31:0] b, input bit stk);
        model_t m;
        int ea, eb, effA, effB, effBig, effSmall, d;
        logic [23:0] ma, mb, smallM;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        effA = (ea == 0) ? 1 : ea;
        effB = (eb == 0) ? 1 : eb;
        ma   = ((ea != 0) ? 24'h800000 : 24'h0) + 24'(a[22:0]);
        mb   = ((eb != 0) ? 24'h800000 : 24'h0) + 24'(b[22:0]);
        m = '0;
        if (effB > effA) begin
            m.sw = 1; m.bigMant = mb; smallM = ma; m.cexp = 8'(eb);
            m.bs = b[31]; m.ss = a[31]; effBig = effB; effSmall = effA;
        end else begin
            m.sw = 0; m.bigMant = ma; smallM = mb; m.cexp = 8'(ea);
            m.bs = a[31]; m.ss = b[31]; effBig = effA; effSmall = effB;
        end
        d = effBig - effSmall;
        m.diff = 8'(d);
        m.smallRaw = smallM;
        if (d == 0) begin
            m.smallMant = smallM; m.lat = 2;
        end else if (d > 24) begin
            m.smallMant = 0; m.lat = 2;
        end else begin
            m.shift = 1;
            if (stk) begin
                m.smallMant = 0; m.err = 1; m.lat = 4 + MAX_WAIT;
            end else begin
                m.smallMant = smallM >> d; m.lat = 4 + d;
            end
        end
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model bookkeeping: mCount is the number of cycles since the operand pair was accepted.
    always @(posedge clk) begin
        if (clear) begin
            mBusy  <= 0;
            mCount <= 0;
        end else if (!mBusy) begin
            if (inValid) begin
                mBusy  <= 1;
                mCount <= 1;
                mExp   <= modelOf(opA, opB, stuck);
            end
        end else if (mCount >= mExp.lat && outReady) begin
            mBusy  <= 0;
            mCount <= 0;
        end else begin
            mCount <= mCount + 1;
        end
    end

    always @(negedge clk) begin
        #2;
        if (checkEn) begin
            checkOutput("in_ready", 32'(inReady), 32'(!mBusy));
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("out_valid", 32'(outValid), 32'(mBusy && mCount >= mExp.lat));
            checkOutput("sh_load", 32'(shLoad), 32'(mBusy && mExp.shift && mCount == 2));
            checkOutput("sh_direction", 32'(shDirection), 32'h0);
            checkOutput("sh_clear", 32'(shClear), 32'(clear));
            if (mBusy && mExp.shift && mCount == 2) begin
                checkOutput("sh_data", 32'(shData), 32'(mExp.smallRaw));
                checkOutput("sh_count", 32'(shCount), 32'(mExp.diff));
            end
            if (mBusy && mCount >= mExp.lat) begin
                checkOutput("big_mant", 32'(bigMant), 32'(mExp.bigMant));
                checkOutput("small_mant", 32'(smallMant), 32'(mExp.smallMant));
                checkOutput("common_exp", 32'(commonExp), 32'(mExp.cexp));
                checkOutput("big_sign", 32'(bigSign), 32'(mExp.bs));
                checkOutput("small_sign", 32'(smallSign), 32'(mExp.ss));
                checkOutput("swapped", 32'(swapped), 32'(mExp.sw));
                checkOutput("err_timeout", 32'(errTimeout), 32'(mExp.err));
            end
        end
    end

    // Drives one operand pair, pins the model to the row's literals and measures the real latency.
    task automatic applyStimulus(input row_t r, input int readyDelay);
        model_t m;
        int cyc;
        m = modelOf(r.a, r.b, r.stk);
        checkOutput("model_big_mant", 32'(m.bigMant), 32'(r.bigMant));
        checkOutput("model_small_mant", 32'(m.smallMant), 32'(r.smallMant));
        checkOutput("model_latency", 32'(m.lat), 32'(r.lat));
        @(negedge clk);
        opA = r.a; opB = r.b; stuck = r.stk; inValid = 1;
        @(negedge clk);
        inValid = 0;
        cyc = 1;
        while (!outValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(r.lat));
        checkOutput("lit_big_mant", 32'(bigMant), 32'(r.bigMant));
        checkOutput("lit_small_mant", 32'(smallMant), 32'(r.smallMant));
        checkOutput("lit_common_exp", 32'(commonExp), 32'(r.cexp));
        checkOutput("lit_swapped", 32'(swapped), 32'(r.sw));
        checkOutput("lit_big_sign", 32'(bigSign), 32'(r.bs));
        checkOutput("lit_err_timeout", 32'(errTimeout), 32'(r.err));
        repeat (readyDelay) @(negedge clk);
        outReady = 1;
        @(negedge clk);
        outReady = 0;
        stuck = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rows[0]  = '{32'h40400000, 32'h3F800000, 1'b0, 24'hC00000, 24'h400000, 8'h80, 1'b0, 1'b0, 1'b0, 5};
        rows[1]  = '{32'h3F800000, 32'h40400000, 1'b0, 24'hC00000, 24'h400000, 8'h80, 1'b1, 1'b0, 1'b0, 5};
        rows[2]  = '{32'h3F800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 2};
        rows[3]  = '{32'h4C000000, 32'h3F800000, 1'b0, 24'h800000, 24'h000000, 8'h98, 1'b0, 1'b0, 1'b0, 2};
        rows[4]  = '{32'h4B800000, 32'h3F800000, 1'b0, 24'h800000, 24'h000000, 8'h97, 1'b0, 1'b0, 1'b0, 28};
        rows[5]  = '{32'hC0400000, 32'h3F800000, 1'b0, 24'hC00000, 24'h400000, 8'h80, 1'b0, 1'b1, 1'b0, 5};
        rows[6]  = '{32'h00400000, 32'h00800000, 1'b0, 24'h400000, 24'h800000, 8'h00, 1'b0, 1'b0, 1'b0, 2};
        rows[7]  = '{32'h00000001, 32'h01000000, 1'b0, 24'h800000, 24'h000000, 8'h02, 1'b1, 1'b0, 1'b0, 5};
        rows[8]  = '{32'h41200000, 32'h3F800000, 1'b0, 24'hA00000, 24'h100000, 8'h82, 1'b0, 1'b0, 1'b0, 7};
        rows[9]  = '{32'h40400000, 32'h3F800000, 1'b1, 24'hC00000, 24'h000000, 8'h80, 1'b0, 1'b0, 1'b1, 44};
        rows[10] = '{32'h3F800000, 32'h40400000, 1'b0, 24'hC00000, 24'h400000, 8'h80, 1'b1, 1'b0, 1'b0, 5};

        clear = 1; inValid = 0; outReady = 0; opA = '0; opB = '0; stuck = 0;
        @(negedge clk);
        @(negedge clk);
        checkEn = 1;
        clear = 0;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(inReady), 32'h1);
        checkOutput("reset_out_valid", 32'(outValid), 32'h0);
        checkOutput("reset_big_mant", 32'(bigMant), 32'h0);
        checkOutput("reset_small_mant", 32'(smallMant), 32'h0);
        checkOutput("reset_sh_count", 32'(shCount), 32'h0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(rows[i], i % 3);
        end

        // Clear while the shifter is stalled mid-operation.
        @(negedge clk);
        opA = 32'h40400000; opB = 32'h3F800000; stuck = 1; inValid = 1;
        @(negedge clk);
        inValid = 0;
        repeat (5) @(negedge clk);
        checkOutput("pre_clear_busy", 32'(busy), 32'h1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        stuck = 0;
        #1;
        checkOutput("clr_in_ready", 32'(inReady), 32'h1);
        checkOutput("clr_out_valid", 32'(outValid), 32'h0);
        checkOutput("clr_busy", 32'(busy), 32'h0);
        checkOutput("clr_big_mant", 32'(bigMant), 32'h0);
        checkOutput("clr_small_mant", 32'(smallMant), 32'h0);
        checkOutput("clr_common_exp", 32'(commonExp), 32'h0);
        checkOutput("clr_swapped", 32'(swapped), 32'h0);
        checkOutput("clr_err_timeout", 32'(errTimeout), 32'h0);
        checkOutput("clr_sh_data", 32'(shData), 32'h0);
        checkOutput("clr_sh_count", 32'(shCount), 32'h0);
        checkOutput("clr_signs", 32'({bigSign, smallSign}), 32'h0);

        applyStimulus(rows[0], 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_align_sequencer.md
Name: fp_align_sequencer

Overview:
Controls exponent alignment for the 32-bit floating-point adder. It accepts two IEEE-754 single-precision operands and identifies the larger-exponent operand. It drives the external count_shifter (load, count, direction) to right-shift the smaller mantissa by the exponent difference, then presents the aligned mantissa pair and common exponent to the add/normalise stage over a valid/ready handshake.

Parameters:
MANT_W, 24, mantissa width including hidden bit; must match the shifter data width.
EXP_W, 8, exponent width.
MAX_WAIT, 40, cycles allowed in SHIFT before the watchdog aborts.

Ports:
Clk  in  1  clock, rising edge
Clear  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  high only in IDLE
op_a  in  32  IEEE-754 operand A
op_b  in  32  IEEE-754 operand B
sh_load  out  1  shifter parallel-load strobe
sh_data  out  MANT_W  mantissa to load into the shifter
sh_count  out  EXP_W  shift amount
sh_direction  out  1  always 0 (right shift)
sh_clear  out  1  equals Clear (combinational pass-through)
sh_result  in  MANT_W  shifter output
sh_done  in  1  shifter count-exhausted flag (shift_enable)
out_valid  out  1  aligned result valid
out_ready  in  1  downstream accepts
big_mant  out  MANT_W  mantissa of larger-exponent operand
small_mant  out  MANT_W  aligned smaller mantissa
common_exp  out  EXP_W  larger exponent
big_sign  out  1  sign of larger-exponent operand
small_sign  out  1  sign of smaller operand
swapped  out  1  1 when B was selected as big
err_timeout  out  1  watchdog fired for this result
busy  out  1  state != IDLE

Behaviour:
- Reset: while Clear=1 at a clock edge, state goes to IDLE and all registered outputs go to 0. The same applies mid-operation: any in-flight operation is discarded and no out_valid is produced. in_ready=1 in the first cycle after reset.
- Unpacking: hidden bit = (exp != 0). A denormal (exp=0) uses effective exponent 1 for difference computation. common_exp reports the raw larger exponent.
- Selection: B is big iff eff_exp_b > eff_exp_a. Equal exponents select A as big (swapped=0).
- States: IDLE, COMPARE, LOAD, ARM, SHIFT, DONE.
- IDLE: on in_valid && in_ready, register op_a/op_b and move to COMPARE.
- COMPARE: register big/small fields and diff = big_eff - small_eff (EXP_W bits, unsigned, never negative).
  - diff==0: small_mant = small mantissa unshifted; go to DONE.
  - diff>MANT_W: small_mant=0; go to DONE with no shifter access.
  - Otherwise go to LOAD.
- LOAD: sh_load=1 for exactly one cycle, with sh_data = small mantissa and sh_count = diff. Next state ARM.
- ARM: sh_load=0. sh_done is ignored for this one cycle because the counter is reloading.
- SHIFT: sh_load=0. On sh_done=1, capture sh_result into small_mant and go to DONE. The watchdog counts cycles in SHIFT; on reaching MAX_WAIT, small_mant=0, err_timeout=1, go to DONE.
- DONE: out_valid=1. Outputs are stable while out_valid && !out_ready. On out_ready, go to IDLE next cycle, with out_valid=0 and err_timeout cleared.
- sh_load is low in every state except LOAD. sh_count and sh_data hold their last value outside LOAD.
- Latency from accept to out_valid:
  - diff==0 or diff>24: 2 cycles.
  - Shift path: 4 + shifter cycles (diff).
- Throughput: one operation in flight. in_ready=0 from acceptance until return to IDLE.
- No back-to-back acceptance in the same cycle as the DONE→IDLE handshake.

Decomposition:
- Shared package fp_pkg holds:
  - State enum.
  - Field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_MSB=22.
  - MANT_W, EXP_W.
- One natural sub-module: fp_unpack (combinational). It takes a 32-bit word and produces sign, effective exponent, raw exponent and 24-bit mantissa. It is instantiated twice.
- FSM, watchdog counter and output registers live in the top.

Test Plan:
- A=0x40400000 (3.0), B=0x3F800000 (1.0) -> diff=1, one sh_load pulse with sh_count=1 and sh_data=0x800000. Result: big_mant=0xC00000, small_mant=0x400000, common_exp=0x80, swapped=0.
- A=0x3F800000, B=0x40400000 -> swapped=1, big_mant=0xC00000, small_mant=0x400000, big_sign=0.
- A=B=0x3F800000 -> no sh_load, out_valid 2 cycles after accept, small_mant=0x800000, common_exp=0x7F.
- A=0x4C000000 (exp 152), B=0x3F800000 -> diff=25, no sh_load, small_mant=0, 2-cycle latency. A=0x4B800000 (diff 24) -> shift path, small_mant=0.
- Shifter model holds sh_done=0 -> out_valid after MAX_WAIT cycles in SHIFT, err_timeout=1, small_mant=0. A subsequent good operation has err_timeout=0.
- Clear asserted in SHIFT with out_ready held 0 -> next cycle state IDLE, in_ready=1, out_valid=0, all outputs 0. A new operation then completes normally.
